// File: rtl/abcd_if.sv
// abcd_if: command and status bundle between a requester (master) and abcd_sequencer (slave).
interface abcd_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] repeat_n;
    logic             abort;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] seq_cnt;

    modport master (
        output start, repeat_n, abort,
        input  a, b, c, d, busy, done, aborted, seq_cnt
    );

    modport slave (
        input  start, repeat_n, abort,
        output a, b, c, d, busy, done, aborted, seq_cnt
    );
endinterface

// File: rtl/abcd_sequencer.sv
// abcd_sequencer: drives a ##1 b ##1 c ##GAP_CD d for a programmable number of repetitions.
// Define ABCD_SEQ_BACK2BACK_EN to drop the idle GAP cycle between consecutive sequences.
module abcd_sequencer #(
    parameter int GAP_CD = 2,
    parameter int CNT_W  = 8
) (
    input  logic  clk,
    input  logic  rst,
    abcd_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        PA,
        PB,
        PC,
        WAIT,
`ifdef ABCD_SEQ_BACK2BACK_EN
        PD
`else
        PD,
        GAP
`endif
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] rem;
    logic [3:0]       wcnt;
    logic             last;

    assign last = (rem == CNT_W'(1));

    always_comb begin
        nxt = state;
        if (bus.abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    nxt = bus.start ? PA : IDLE;
                PA:      nxt = PB;
                PB:      nxt = PC;
                PC:      nxt = (GAP_CD > 1) ? WAIT : PD;
                WAIT:    nxt = (wcnt == '0) ? PD : WAIT;
`ifdef ABCD_SEQ_BACK2BACK_EN
                PD:      nxt = last ? IDLE : PA;
`else
                PD:      nxt = last ? IDLE : GAP;
                GAP:     nxt = PA;
`endif
                default: nxt = IDLE;
            endcase
        end
    end

    // Strobes and busy are registered from the next state, so they line up with the state they name.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rem         <= '0;
            wcnt        <= '0;
            bus.seq_cnt <= '0;
            bus.a       <= 1'b0;
            bus.b       <= 1'b0;
            bus.c       <= 1'b0;
            bus.d       <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
        end else begin
            state       <= nxt;
            bus.a       <= (nxt == PA);
            bus.b       <= (nxt == PB);
            bus.c       <= (nxt == PC);
            bus.d       <= (nxt == PD);
            bus.busy    <= (nxt != IDLE);
            bus.done    <= !bus.abort && state == PD && last;
            bus.aborted <= bus.abort && state != IDLE;
            if (!bus.abort && state == IDLE && bus.start) begin
                rem         <= (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
                bus.seq_cnt <= '0;
            end
            if (!bus.abort && state == PC)
                wcnt <= (GAP_CD > 1) ? 4'(GAP_CD - 2) : 4'd0;
            else if (!bus.abort && state == WAIT)
                wcnt <= wcnt - 4'd1;
            if (!bus.abort && state == PD) begin
                rem         <= rem - CNT_W'(1);
                bus.seq_cnt <= bus.seq_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_abcd_sequencer.sv
// tb_abcd_sequencer: scoreboard bench; stimulus pushes expected strobe/done/aborted events, a negedge monitor pops them.
module tb_abcd_sequencer;
    localparam int CNT_W = 8;
    localparam int G0    = 2;
    localparam int G1    = 1;
`ifdef ABCD_SEQ_BACK2BACK_EN
    localparam int EXTRA = 0;
`else
    localparam int EXTRA = 1;
`endif
    localparam logic [5:0] EV_A = 6'b100000, EV_B = 6'b010000, EV_C = 6'b001000;
    localparam logic [5:0] EV_D = 6'b000100, EV_DONE = 6'b000010, EV_ABT = 6'b000001;

    typedef struct {
        int         dut;
        int         at;
        logic [5:0] ev;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic             start_v [2];
    logic             abort_v [2];
    logic [CNT_W-1:0] rep_v   [2];
    logic [5:0]       ev_v    [2];
    logic             busy_v  [2];
    logic [CNT_W-1:0] cnt_v   [2];
    exp_t             sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < 2; i++) begin : g
        abcd_if #(.CNT_W(CNT_W)) bus ();
        assign bus.start    = start_v[i];
        assign bus.abort    = abort_v[i];
        assign bus.repeat_n = rep_v[i];
        assign ev_v[i]      = {bus.a, bus.b, bus.c, bus.d, bus.done, bus.aborted};
        assign busy_v[i]    = bus.busy;
        assign cnt_v[i]     = bus.seq_cnt;
        abcd_sequencer #(.GAP_CD(i == 0 ? G0 : G1), .CNT_W(CNT_W)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (ev_v[i] != '0) begin
                    int j;
                    j = -1;
                    foreach (sb[k]) if (j < 0 && sb[k].dut == i) j = k;
                    if (j < 0) begin
                        chk($sformatf("unexpected_event_dut%0d", i), ev_v[i], 0);
                    end else begin
                        chk($sformatf("event_kind_dut%0d", i), ev_v[i], sb[j].ev);
                        chk($sformatf("event_cycle_dut%0d", i), cyc, sb[j].at);
                        sb.delete(j);
                    end
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(int i, int at, logic [5:0] e);
        exp_t x;
        x.dut = i;
        x.at  = at;
        x.ev  = e;
        sb.push_back(x);
    endtask

    task automatic expect_seq(int i, int base, int g);
        push(i, base, EV_A);
        push(i, base + 1, EV_B);
        push(i, base + 2, EV_C);
        push(i, base + 2 + g, EV_D);
    endtask

    task automatic launch(int i, int n, int g, bit predict, output int t0);
        int nn;
        int p;
        t0 = cyc;
        start_v[i] = 1'b1;
        rep_v[i]   = CNT_W'(n);
        nn = (n == 0) ? 1 : n;
        p  = g + 3 + EXTRA;
        if (predict) begin
            for (int r = 0; r < nn; r++) expect_seq(i, t0 + 1 + r * p, g);
            push(i, t0 + 1 + (nn - 1) * p + 3 + g, EV_DONE);
        end
        tick();
        start_v[i] = 1'b0;
    endtask

    task automatic wait_idle(int i);
        int k;
        k = 0;
        while (busy_v[i] && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) chk("idle_timeout", 1, 0);
        tick(2);
    endtask

    initial begin
        int t0;
        int base2;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
            rep_v[i]   = '0;
        end
        tick(3);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_strobes%0d", i), ev_v[i], 0);
            chk($sformatf("reset_busy%0d", i), busy_v[i], 0);
            chk($sformatf("reset_seq_cnt%0d", i), cnt_v[i], 0);
        end
        rst = 1'b0;
        tick(2);

        // single run: busy over the sequence, falls with done
        launch(0, 1, G0, 1'b1, t0);
        chk("single_busy_start", busy_v[0], 1);
        tick(4);
        chk("single_busy_last_d", busy_v[0], 1);
        tick();
        chk("single_busy_done", busy_v[0], 0);
        chk("single_seq_cnt", cnt_v[0], 1);
        wait_idle(0);

        launch(0, 3, G0, 1'b1, t0);
        wait_idle(0);
        chk("repeat3_seq_cnt", cnt_v[0], 3);

        launch(0, 0, G0, 1'b1, t0);
        wait_idle(0);
        chk("repeat0_seq_cnt", cnt_v[0], 1);

        // start while busy must not restart or resample repeat_n
        launch(0, 1, G0, 1'b1, t0);
        tick();
        start_v[0] = 1'b1;
        rep_v[0]   = 8'd5;
        tick();
        start_v[0] = 1'b0;
        wait_idle(0);
        chk("busy_start_seq_cnt", cnt_v[0], 1);

        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        rep_v[0]   = 8'd1;
        tick();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("idle_abort_busy", busy_v[0], 0);
        tick(10);
        chk("idle_abort_busy_later", busy_v[0], 0);

        // abort in WAIT of the second sequence
        launch(0, 3, G0, 1'b0, t0);
        base2 = t0 + 1 + (G0 + 3 + EXTRA);
        expect_seq(0, t0 + 1, G0);
        push(0, base2, EV_A);
        push(0, base2 + 1, EV_B);
        push(0, base2 + 2, EV_C);
        push(0, base2 + 4, EV_ABT);
        tick(base2 + 3 - cyc);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        chk("abort_busy", busy_v[0], 0);
        chk("abort_seq_cnt", cnt_v[0], 1);
        tick(20);
        chk("abort_seq_cnt_hold", cnt_v[0], 1);

        // asynchronous reset during WAIT
        launch(0, 2, G0, 1'b0, t0);
        push(0, t0 + 1, EV_A);
        push(0, t0 + 2, EV_B);
        push(0, t0 + 3, EV_C);
        tick(3);
        rst = 1'b1;
        #1;
        chk("midrst_strobes", ev_v[0], 0);
        chk("midrst_busy", busy_v[0], 0);
        chk("midrst_seq_cnt", cnt_v[0], 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        launch(0, 1, G0, 1'b1, t0);
        wait_idle(0);
        chk("post_rst_seq_cnt", cnt_v[0], 1);

        launch(1, 2, G1, 1'b1, t0);
        wait_idle(1);
        chk("gap1_seq_cnt", cnt_v[1], 2);

        tick(5);
        chk("scoreboard_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/abcd_sequencer.md
# abcd_sequencer

Registered controller that drives the four-phase strobe pattern a, then b, then c, then d GAP_CD cycles after c. On a start command it runs a programmable number of repetitions and reports them through a start/busy/done handshake. It sits in front of any block whose input contract is `a ##1 b ##1 c ##GAP_CD d`, including the existing assertion bench. Its outputs meet that property by construction.

## Interface
- GAP_CD, default 2: cycles from c to d; legal range 1..15.
- CNT_W, default 8: width of the repeat count and of seq_cnt.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- repeat_n  in  CNT_W  number of sequences in the run; sampled with start; 0 is treated as 1.
- abort  in  1  synchronous abort; takes priority over every other input.
- a, b, c, d  out  1 each  phase strobes; registered; at most one is high in any cycle.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse after the last d of a run.
- aborted  out  1  one-cycle pulse after an accepted abort.
- seq_cnt  out  CNT_W  sequences completed in the current run; holds its value after done.

## Operation
- States: IDLE, PA, PB, PC, WAIT, PD, GAP.
- IDLE: when start=1 and abort=0, latch max(repeat_n,1) into rem and clear seq_cnt; next state PA.
- PA → PB → PC, one cycle each.
- PC → WAIT when GAP_CD>1, otherwise → PD.
- WAIT: lasts GAP_CD-1 cycles, counted by a 4-bit down-counter; then → PD.
- PD: increment seq_cnt and decrement rem.
  - rem was 1: → IDLE, with done=1 in the following cycle.
  - Otherwise: → GAP, or → PA directly when back-to-back mode is enabled.
- GAP: one idle cycle with all strobes low; → PA.
- Strobe decode: a=1 only in PA, b=1 only in PB, c=1 only in PC, d=1 only in PD. Outputs are registered from the next state.
- busy=1 in every state except IDLE.
- start while busy: ignored; the run is not restarted and repeat_n is not resampled.
- abort=1 in any non-IDLE state:
  - Next cycle: state IDLE, all strobes 0, busy 0, aborted=1, done stays 0.
  - seq_cnt keeps the number of sequences already completed.
- abort=1 in IDLE: no effect and no aborted pulse. It blocks a start asserted in the same cycle.
- rst asserted: every output goes to 0 immediately, including mid-run. The FSM enters IDLE and rem and the wait counter clear.
- seq_cnt wraps modulo 2^CNT_W; it cannot overflow within one run because rem ≤ 2^CNT_W-1.

## Timing
- Start sampled at edge k: a=1 in cycle k+1, b in k+2, c in k+3, d in k+3+GAP_CD.
- Length of one sequence: GAP_CD+3 cycles.
- Repetition period: GAP_CD+4 cycles with the GAP cycle, GAP_CD+3 cycles back-to-back.
- done occurs one cycle after the final d. busy falls in the same cycle done rises.
- Earliest new start: sampled in the done cycle, with its a one cycle later.
- Abort reaction: one cycle. A strobe scheduled for the cycle after the abort is suppressed.

## Configuration
- Macro: ABCD_SEQ_BACK2BACK_EN.
- Defined: the GAP state is not compiled. After PD with repetitions left, the FSM goes straight to PA, so the next a follows d in the next cycle.
- Undefined (default): one all-low GAP cycle separates consecutive sequences.
- Both builds satisfy `a ##1 b ##1 c ##GAP_CD d` for every sequence.

## Test plan
- Reset at mid-run: assert rst during WAIT → all outputs 0 within the same cycle, no done. After release, start works normally.
- Single run, GAP_CD=2, start at cycle 0, repeat_n=1 → a@1, b@2, c@3, d@5, done@6, busy high 1–5, seq_cnt=1.
- Repeat, default build, repeat_n=3 → a@1,7,13; d@5,11,17; done@18; seq_cnt=3.
- Repeat, ABCD_SEQ_BACK2BACK_EN, repeat_n=3 → a@1,6,11; d@5,10,15; done@16.
- Abort in WAIT of sequence 2 (repeat_n=3, default build) → no d for sequence 2, aborted pulse the next cycle, seq_cnt=1, done never asserted.
- Boundary cases:
  - repeat_n=0 → exactly one sequence.
  - GAP_CD=1 → d the cycle after c.
  - start and abort high together in IDLE → no run.
  - start during busy → ignored.
